// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: sizes, sequencer state encoding and the round
// constant table (also used by the compression core).
package sha256_pkg;

    localparam int WORD_W    = 32;
    localparam int BLK_WORDS = 16;
    localparam int ROUNDS    = 64;
    localparam int IDX_W     = 6;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // K_t: first 32 bits of the fractional parts of the cube roots of the first 64 primes.
    localparam logic [WORD_W-1:0] K_TABLE [ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational round-constant lookup: round index -> K_t.
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic [IDX_W-1:0]  idx,
    output logic [WORD_W-1:0] k
);

    // Pure table lookup, no state.
    always_comb begin
        k = K_TABLE[idx];
    end

endmodule

// File: rtl/sha256_sched_ctrl.sv
// Message-schedule sequencer: buffers one 16-word block from the source, then
// walks MOD_W_MEM through rounds 0..63 and issues W_t / K_t to the round core.
//
// Handshake: a word moves on BLK_WORD in every cycle where BLK_VALID and
// BLK_READY are both high at the rising edge of CLK. BLK_READY does not depend
// on BLK_VALID; the source may hold BLK_VALID low for any number of cycles and
// must keep BLK_WORD stable while BLK_VALID is high and BLK_READY is low.
module sha256_sched_ctrl
    import sha256_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic              ABORT,
    input  logic              BLK_VALID,
    input  logic [WORD_W-1:0] BLK_WORD,
    output logic              BLK_READY,
    output logic [IDX_W-1:0]  W_I,
    output logic [WORD_W-1:0] W_D_IN,
    input  logic [WORD_W-1:0] W_D_OUT,
    output logic              RND_VALID,
    output logic [IDX_W-1:0]  RND_T,
    output logic [WORD_W-1:0] RND_W,
    output logic [WORD_W-1:0] RND_K,
    output logic              RND_FIRST,
    output logic              RND_LAST,
    output logic              DONE,
    output logic              BUSY,
    output logic [1:0]        DBG_STATE
);

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  t_q;
    logic [WORD_W-1:0] blk_buf [BLK_WORDS];
    logic [WORD_W-1:0] k_t;
    logic              accept;
    logic              last_accept;
    logic              last_round;

    sha256_k_rom u_k_rom (
        .idx (t_q),
        .k   (k_t)
    );

    assign DBG_STATE = state_q;

    // Next-state and output decode; everything outside RUN is driven to zero.
    always_comb begin
        state_d     = state_q;
        BLK_READY   = 1'b0;
        W_I         = '0;
        W_D_IN      = '0;
        RND_VALID   = 1'b0;
        RND_T       = '0;
        RND_W       = '0;
        RND_K       = '0;
        RND_FIRST   = 1'b0;
        RND_LAST    = 1'b0;
        DONE        = 1'b0;
        BUSY        = (state_q != ST_IDLE);
        accept      = 1'b0;
        last_accept = 1'b0;
        last_round  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                BLK_READY   = 1'b1;
                accept      = BLK_VALID;
                last_accept = BLK_VALID && (cnt_q == CNT_W'(BLK_WORDS - 1));
                if (last_accept) state_d = ST_RUN;
            end
            ST_RUN: begin
                W_I        = t_q;
                // Message words feed the memory only for the first 16 rounds.
                W_D_IN     = (t_q < IDX_W'(BLK_WORDS)) ? blk_buf[t_q[CNT_W-1:0]] : '0;
                RND_VALID  = 1'b1;
                RND_T      = t_q;
                RND_W      = W_D_OUT;
                RND_K      = k_t;
                RND_FIRST  = (t_q == '0);
                last_round = (t_q == IDX_W'(ROUNDS - 1));
                RND_LAST   = last_round;
                if (last_round) state_d = ST_DONE;
            end
            ST_DONE: begin
                DONE    = 1'b1;
                state_d = START ? ST_LOAD : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort overrides every transition, including the 16th accept.
        if (ABORT) state_d = ST_IDLE;
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Word counter and round counter; both clear on abort and at the end of their phase.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
            t_q   <= '0;
        end else if (ABORT) begin
            cnt_q <= '0;
            t_q   <= '0;
        end else begin
            if (accept) cnt_q <= last_accept ? '0 : cnt_q + CNT_W'(1);
            if (state_q == ST_RUN) t_q <= last_round ? '0 : t_q + IDX_W'(1);
        end
    end

    // Block buffer; contents are don't-care after reset so it carries no reset.
    always_ff @(posedge CLK) begin
        if (accept && !ABORT) blk_buf[cnt_q] <= BLK_WORD;
    end

endmodule
